// File: rtl/de0_cv_switch_ctrl.sv
// Avalon-MM slide-switch controller: 2-flop sync, per-bit tick-based debounce,
// edge capture with W1C clear, and a masked level interrupt.
module de0_cv_switch_ctrl #(
  parameter int WIDTH     = 10,
  parameter int TICK_DIV  = 50000,
  parameter int CNT_W     = 8,
  parameter int LIMIT_RST = 10,
  parameter int EDGE_MODE = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int              PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } db_state_e;

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             tick;
  logic [WIDTH-1:0] stable_w;
  logic [WIDTH-1:0] stable_dly_q, stable_dly_d;
  logic [WIDTH-1:0] rise, fall, ev;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [CNT_W-1:0] limit_q, limit_d;
  logic             irq_q, irq_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             wr_en;
  logic [WIDTH-1:0] w1c_bits;
  logic             unused_wdata;

  assign unused_wdata = &{1'b0, writedata};
  assign wr_en        = chipselect & ~write_n;

  always_comb begin
    sync1_d = in_port;
    sync2_d = sync1_q;
  end

  always_comb begin
    tick    = (presc_q == PRESC_MAX);
    presc_d = tick ? '0 : presc_q + PW'(1);
  end

  // Each switch bit owns an independent two-state debounce machine.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_db
      db_state_e        st_q, st_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             stab_q, stab_d;
      logic [CNT_W:0]   cnt_inc;

      always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q;
        stab_d  = stab_q;
        cnt_inc = {1'b0, cnt_q} + (CNT_W + 1)'(1);
        case (st_q)
          ST_STABLE: begin
            cnt_d = '0;
            if (sync2_q[gi] != stab_q) st_d = ST_COUNTING;
          end
          ST_COUNTING: begin
            if (sync2_q[gi] == stab_q) begin
              cnt_d = '0;
              st_d  = ST_STABLE;
            end else if (tick) begin
              // Compare against the live limit so a mid-count write applies at once.
              if (cnt_inc >= {1'b0, limit_q}) begin
                stab_d = sync2_q[gi];
                cnt_d  = '0;
                st_d   = ST_STABLE;
              end else if (cnt_q != CNT_SAT) begin
                cnt_d = cnt_inc[CNT_W-1:0];
              end
            end
          end
          default: st_d = ST_STABLE;
        endcase
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          st_q   <= ST_STABLE;
          cnt_q  <= '0;
          stab_q <= 1'b0;
        end else begin
          st_q   <= st_d;
          cnt_q  <= cnt_d;
          stab_q <= stab_d;
        end
      end

      assign stable_w[gi] = stab_q;
    end
  endgenerate

  always_comb begin
    stable_dly_d = stable_w;
    rise         = stable_w & ~stable_dly_q;
    fall         = ~stable_w & stable_dly_q;
    if (EDGE_MODE == 0)      ev = rise;
    else if (EDGE_MODE == 1) ev = fall;
    else                     ev = rise | fall;
  end

  always_comb begin
    w1c_bits = (wr_en && address == 3'd3) ? writedata[WIDTH-1:0] : '0;
    // New events are OR-ed in after the clear so a simultaneous set wins.
    edge_cap_d = (edge_cap_q & ~w1c_bits) | ev;
    mask_d     = mask_q;
    limit_d    = limit_q;
    if (wr_en && address == 3'd2) mask_d = writedata[WIDTH-1:0];
    if (wr_en && address == 3'd4) begin
      limit_d = (writedata[CNT_W-1:0] == '0) ? CNT_W'(1) : writedata[CNT_W-1:0];
    end
    irq_d = |(edge_cap_q & mask_q);
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      3'd0: readdata_d[WIDTH-1:0] = stable_w;
      3'd1: readdata_d[WIDTH-1:0] = sync2_q;
      3'd2: readdata_d[WIDTH-1:0] = mask_q;
      3'd3: readdata_d[WIDTH-1:0] = edge_cap_q;
      3'd4: readdata_d[CNT_W-1:0] = limit_q;
      3'd5: readdata_d[1:0]       = {|edge_cap_q, |(edge_cap_q & mask_q)};
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      presc_q      <= '0;
      stable_dly_q <= '0;
      edge_cap_q   <= '0;
      mask_q       <= '0;
      limit_q      <= CNT_W'(LIMIT_RST);
      irq_q        <= 1'b0;
      readdata_q   <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      presc_q      <= presc_d;
      stable_dly_q <= stable_dly_d;
      edge_cap_q   <= edge_cap_d;
      mask_q       <= mask_d;
      limit_q      <= limit_d;
      irq_q        <= irq_d;
      readdata_q   <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_de0_cv_switch_ctrl.sv
// Self-checking bench for de0_cv_switch_ctrl: directed register/debounce scenarios
// followed by randomized glitch-and-hold segments against a level/edge model.
module tb_de0_cv_switch_ctrl;

  localparam int W  = 10;
  localparam int TD = 4;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [W-1:0] in_port;
  logic        irq;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  de0_cv_switch_ctrl #(
    .WIDTH(W), .TICK_DIV(TD), .CNT_W(8), .LIMIT_RST(10), .EDGE_MODE(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("  ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask

  task automatic read_check(input string tag, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check_eq(tag, d, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns the sample index (1-based, one per cycle) at which DATA matches; 0 on timeout.
  task automatic poll_data(input logic [W-1:0] m, input logic [W-1:0] val,
                           input int max, output int k);
    address = 3'd0;
    k = 0;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if ((readdata[W-1:0] & m) == val) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic align_phase();
    @(negedge clk);
    while (cyc % TD != 0) @(negedge clk);
  endtask

  int          k;
  int          press_k;
  logic        irq_s;
  logic [W-1:0] p_m, cap_m, mask_m, v, g;
  logic [31:0] w;
  int          lim, dly;

  initial begin
    reset_n = 1'b0; in_port = 10'h3FF; address = 3'd0;
    chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;

    // Reset state with all switches high
    idle(3);
    #1;
    check_eq("rst_readdata", readdata, 32'd0);
    check_eq("rst_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    poll_data(10'h3FF, 10'h3FF, 2 + 11 * TD, k);
    check_eq("rst_data_found", {31'd0, k != 0}, 32'd1);
    read_check("rst_limit", 3'd4, 32'd10);
    read_check("rst_edgecap", 3'd3, 32'h3FF);
    read_check("rst_status", 3'd5, 32'd2);
    check_eq("rst_irq_masked", {31'd0, irq}, 32'd0);

    in_port = '0;
    idle(60);
    read_check("all_low_data", 3'd0, 32'd0);
    bus_write(3'd3, 32'h3FF);
    read_check("cap_cleared", 3'd3, 32'd0);

    // Register access
    bus_write(3'd4, 32'd0);
    read_check("limit_zero_is_one", 3'd4, 32'd1);
    bus_write(3'd6, 32'hFFFF_FFFF);
    read_check("unmapped6_read", 3'd6, 32'd0);
    read_check("unmapped_mask", 3'd2, 32'd0);
    read_check("unmapped_limit", 3'd4, 32'd1);
    read_check("unmapped_cap", 3'd3, 32'd0);
    bus_write(3'd2, 32'hFFFF_FFFF);
    read_check("mask_width", 3'd2, 32'h3FF);
    read_check("unmapped7_read", 3'd7, 32'd0);
    bus_write(3'd2, 32'd0);

    // Bounce rejection: pulses of 8 cycles against limit 3 x 4-cycle ticks
    bus_write(3'd4, 32'd3);
    for (int i = 0; i < 12; i++) begin
      in_port[0] = ~in_port[0];
      idle(8);
    end
    idle(30);
    read_check("bounce_data", 3'd0, 32'd0);
    read_check("bounce_cap", 3'd3, 32'd0);

    // Clean press on bit 5 with irq enabled
    bus_write(3'd2, 32'h020);
    align_phase();
    in_port[5] = 1'b1;
    poll_data(10'h020, 10'h020, 30, k);
    press_k = k;
    irq_s = irq;
    check_eq("press_latency_ok", {31'd0, (k >= 12 && k <= 18)}, 32'd1);
    // readdata exposes the new level one cycle after it changes; irq lags it by one more
    check_eq("press_irq_pre", {31'd0, irq_s}, 32'd0);
    @(negedge clk);
    check_eq("press_irq_post", {31'd0, irq}, 32'd1);
    read_check("press_cap", 3'd3, 32'h020);
    read_check("press_data", 3'd0, 32'h020);
    read_check("press_status", 3'd5, 32'd3);

    // W1C race: clear write lands on the same edge that captures the release edge
    bus_write(3'd3, 32'h020);
    idle(3);
    check_eq("race_pre_irq", {31'd0, irq}, 32'd0);
    read_check("race_pre_cap", 3'd3, 32'd0);
    align_phase();
    in_port[5] = 1'b0;
    repeat (press_k - 1) @(negedge clk);
    address = 3'd3; writedata = 32'h020; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    read_check("race_cap_set_wins", 3'd3, 32'h020);
    check_eq("race_irq", {31'd0, irq}, 32'd1);
    read_check("race_data", 3'd0, 32'd0);
    bus_write(3'd3, 32'h020);
    check_eq("clr_irq_hold", {31'd0, irq}, 32'd1);
    @(negedge clk);
    check_eq("clr_irq_drop", {31'd0, irq}, 32'd0);
    read_check("clr_cap", 3'd3, 32'd0);

    // Randomized segments: optional glitches followed by a long hold
    p_m = '0; cap_m = '0; mask_m = 10'h020;
    for (int s = 0; s < 24; s++) begin
      lim = $urandom_range(2, 6);
      bus_write(3'd4, 32'(lim));
      if ($urandom_range(0, 1) == 1) begin
        w = $urandom;
        bus_write(3'd2, w);
        mask_m = w[W-1:0];
      end
      if ($urandom_range(0, 1) == 1) begin
        w = $urandom;
        bus_write(3'd3, w);
        cap_m = cap_m & ~w[W-1:0];
      end
      w = $urandom; v = w[W-1:0];
      w = $urandom; g = w[W-1:0];
      dly = $urandom_range(1, (lim - 1) * TD);
      in_port = v ^ g;
      idle(dly);
      in_port = v;
      idle(2 + lim * TD + 2 * TD + 4);
      cap_m = cap_m | (v ^ p_m);
      p_m = v;
      read_check($sformatf("seg%0d_data", s), 3'd0, 32'(v));
      read_check($sformatf("seg%0d_raw", s), 3'd1, 32'(v));
      read_check($sformatf("seg%0d_cap", s), 3'd3, 32'(cap_m));
      read_check($sformatf("seg%0d_status", s), 3'd5,
                 {30'd0, |cap_m, |(cap_m & mask_m)});
      check_eq($sformatf("seg%0d_irq", s), {31'd0, irq}, {31'd0, |(cap_m & mask_m)});
    end

    // Mid-operation reset while counting
    in_port = '0;
    idle(60);
    bus_write(3'd3, 32'h3FF);
    bus_write(3'd2, 32'd0);
    bus_write(3'd4, 32'd3);
    in_port[1] = 1'b1;
    idle(8);
    reset_n = 1'b0;
    #1;
    check_eq("mrst1_readdata", readdata, 32'd0);
    check_eq("mrst1_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    poll_data(10'h002, 10'h002, 60, k);
    check_eq("mrst1_restart_latency", {31'd0, (k >= 36 && k <= 50)}, 32'd1);
    read_check("mrst1_limit", 3'd4, 32'd10);
    read_check("mrst1_mask", 3'd2, 32'd0);
    read_check("mrst1_cap", 3'd3, 32'h002);

    // Mid-operation reset while irq is asserted
    bus_write(3'd2, 32'h002);
    idle(3);
    check_eq("mrst2_irq_before", {31'd0, irq}, 32'd1);
    reset_n = 1'b0;
    #1;
    check_eq("mrst2_irq", {31'd0, irq}, 32'd0);
    check_eq("mrst2_readdata", readdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    poll_data(10'h002, 10'h002, 60, k);
    check_eq("mrst2_data_found", {31'd0, k != 0}, 32'd1);
    idle(3);
    check_eq("mrst2_irq_masked", {31'd0, irq}, 32'd0);
    read_check("mrst2_cap", 3'd3, 32'h002);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
